// File: rtl/resp_misr_32bit_pkg.sv
// Shared definitions for the response compactor: FSM encoding and default MISR polynomial.
package resp_misr_32bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'h00000000;

endpackage

// File: rtl/resp_misr_32bit_if.sv
// Control, result-stream and status bundle for resp_misr_32bit.
interface resp_misr_32bit_if;
  import resp_misr_32bit_pkg::*;

  logic        start;
  logic [15:0] length;
  logic [31:0] golden;
  // Stream handshake: a word transfers on the rising edge where in_valid and
  // in_ready are both high; in_valid without in_ready leaves all state untouched.
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] signature;
  state_t      dbg_state;

  modport master (
    output start, length, golden, in_valid, in_data,
    input  in_ready, busy, done, pass, timeout, signature, dbg_state
  );

  modport slave (
    input  start, length, golden, in_valid, in_data,
    output in_ready, busy, done, pass, timeout, signature, dbg_state
  );
endinterface

// File: rtl/misr_step_32bit.sv
// One MISR step: shift left, fold the polynomial back in when bit 31 falls out, XOR in data.
module misr_step_32bit #(
  parameter logic [31:0] POLY = 32'h04C11DB7
) (
  input  logic [31:0] sig,
  input  logic [31:0] data,
  output logic [31:0] next
);
  assign next = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ data;
endmodule

// File: rtl/resp_misr_32bit.sv
// Response compactor: folds a run of result words into a MISR and compares against golden.
// Optional RESP_TIMEOUT_EN ends a stalled run after TIMEOUT idle cycles in ACCUM.
module resp_misr_32bit
  import resp_misr_32bit_pkg::*;
#(
  parameter logic [31:0] POLY    = DEFAULT_POLY,
  parameter logic [31:0] SEED    = DEFAULT_SEED,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic               clk,
  input  logic               reset,
  resp_misr_32bit_if.slave   bus
);

  state_t      state;
  logic [31:0] sig;
  logic [31:0] sig_next;
  logic [15:0] count;
  logic [15:0] len_q;
  logic [31:0] golden_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic        accept;
  logic        last_word;

  misr_step_32bit #(.POLY(POLY)) u_step (
    .sig  (sig),
    .data (bus.in_data),
    .next (sig_next)
  );

  assign accept    = bus.in_valid && in_ready_q;
  assign last_word = (16'(count + 16'd1) == len_q);

`ifdef RESP_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        timeout_q;
  logic        idle_expired;

  assign idle_expired = (idle_cnt == 16'(TIMEOUT - 16'd1));
  assign bus.timeout  = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign bus.timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sig        <= SEED;
      count      <= 16'd0;
      len_q      <= 16'd0;
      golden_q   <= 32'h0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      idle_cnt   <= 16'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            len_q    <= bus.length;
            golden_q <= bus.golden;
            sig      <= SEED;
            count    <= 16'd0;
            busy_q   <= 1'b1;
`ifdef RESP_TIMEOUT_EN
            idle_cnt  <= 16'd0;
            timeout_q <= 1'b0;
`endif
            // An empty run completes immediately against the seed value.
            if (bus.length == 16'd0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              pass_q <= (SEED == bus.golden);
            end else begin
              state      <= ST_ACCUM;
              in_ready_q <= 1'b1;
              pass_q     <= 1'b0;
            end
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            sig   <= sig_next;
            count <= 16'(count + 16'd1);
`ifdef RESP_TIMEOUT_EN
            idle_cnt <= 16'd0;
`endif
            if (last_word) begin
              state      <= ST_DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
              pass_q     <= (sig_next == golden_q);
            end
          end
`ifdef RESP_TIMEOUT_EN
          else if (idle_expired) begin
            state      <= ST_DONE;
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b1;
          end else begin
            idle_cnt <= 16'(idle_cnt + 16'd1);
          end
`endif
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_resp_misr_32bit.sv
// Directed bench for resp_misr_32bit; expected signatures are hand-computed MISR values.
module tb_resp_misr_32bit;
  import resp_misr_32bit_pkg::*;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_checks;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  resp_misr_32bit_if bus();

  resp_misr_32bit #(
    .POLY    (32'h04C11DB7),
    .SEED    (32'h00000000),
    .TIMEOUT (16'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.length   = 16'd0;
    bus.golden   = 32'h0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
  endtask

  task automatic do_start(input logic [15:0] len, input logic [31:0] gold);
    bus.start  = 1'b1;
    bus.length = len;
    bus.golden = gold;
    tick();
    bus.start  = 1'b0;
    bus.length = 16'hFFFF;
    bus.golden = 32'hA5A5A5A5;
  endtask

  task automatic send_word(input logic [31:0] data);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) tick();

    // reset / idle state
    check("rst_signature", bus.signature, 32'h0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);
    check("rst_pass", {31'b0, bus.pass}, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_timeout", {31'b0, bus.timeout}, 32'h0);
    check("rst_state", {30'b0, bus.dbg_state}, {30'b0, ST_IDLE});

    // single-word run
    do_start(16'd1, 32'h0F0F0F0F);
    check("a_in_ready", {31'b0, bus.in_ready}, 32'h1);
    check("a_busy", {31'b0, bus.busy}, 32'h1);
    send_word(32'h0F0F0F0F);
    check("a_sig", bus.signature, 32'h0F0F0F0F);
    check("a_done", {31'b0, bus.done}, 32'h1);
    check("a_pass", {31'b0, bus.pass}, 32'h1);
    check("a_ready_done", {31'b0, bus.in_ready}, 32'h0);
    tick();
    check("a_done_clr", {31'b0, bus.done}, 32'h0);
    check("a_busy_clr", {31'b0, bus.busy}, 32'h0);
    check("a_pass_hold", {31'b0, bus.pass}, 32'h1);

    // two-word run, shift with polynomial feedback
    exp_q.push_back(32'hF000F000);
    exp_q.push_back(32'h1B3FFDB7);
    do_start(16'd2, 32'h1B3FFDB7);
    send_word(32'hF000F000);
    exp_v = exp_q.pop_front();
    check("b_sig1", bus.signature, exp_v);
    check("b_done_mid", {31'b0, bus.done}, 32'h0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF0000;
    tick();
    bus.in_data  = 32'hDEADBEEF;
    exp_v = exp_q.pop_front();
    check("b_sig2", bus.signature, exp_v);
    check("b_done", {31'b0, bus.done}, 32'h1);
    check("b_pass", {31'b0, bus.pass}, 32'h1);
    tick();
    check("b_sig_in_done", bus.signature, 32'h1B3FFDB7);
    tick();
    check("b_sig_in_idle", bus.signature, 32'h1B3FFDB7);
    bus.in_valid = 1'b0;

    // same words, wrong golden
    do_start(16'd2, 32'h00000000);
    check("c_pass_clr", {31'b0, bus.pass}, 32'h0);
    check("c_sig_seed", bus.signature, 32'h0);
    send_word(32'hF000F000);
    send_word(32'hFFFF0000);
    check("c_sig", bus.signature, 32'h1B3FFDB7);
    check("c_done", {31'b0, bus.done}, 32'h1);
    check("c_pass", {31'b0, bus.pass}, 32'h0);
    tick();

    // zero-length runs
    do_start(16'd0, 32'h00000000);
    check("d0_done", {31'b0, bus.done}, 32'h1);
    check("d0_pass", {31'b0, bus.pass}, 32'h1);
    check("d0_ready", {31'b0, bus.in_ready}, 32'h0);
    tick();
    check("d0_done_clr", {31'b0, bus.done}, 32'h0);
    do_start(16'd0, 32'h00000005);
    check("d1_done", {31'b0, bus.done}, 32'h1);
    check("d1_pass", {31'b0, bus.pass}, 32'h0);
    tick();

    // start during ACCUM ignored: words 1,2,3 -> 1, 0, 3
    do_start(16'd3, 32'h00000003);
    send_word(32'h00000001);
    check("e_sig1", bus.signature, 32'h00000001);
    bus.start  = 1'b1;
    bus.length = 16'd1;
    bus.golden = 32'hFFFFFFFF;
    send_word(32'h00000002);
    bus.start  = 1'b0;
    check("e_sig2", bus.signature, 32'h00000000);
    check("e_no_done", {31'b0, bus.done}, 32'h0);
    send_word(32'h00000003);
    check("e_sig3", bus.signature, 32'h00000003);
    check("e_done", {31'b0, bus.done}, 32'h1);
    check("e_pass", {31'b0, bus.pass}, 32'h1);
    tick();

    // asynchronous reset mid-run
    do_start(16'd3, 32'h12345678);
    send_word(32'h0000ABCD);
    check("f_sig1", bus.signature, 32'h0000ABCD);
    reset = 1'b1;
    #1;
    check("f_rst_sig", bus.signature, 32'h0);
    check("f_rst_busy", {31'b0, bus.busy}, 32'h0);
    check("f_rst_ready", {31'b0, bus.in_ready}, 32'h0);
    check("f_rst_state", {30'b0, bus.dbg_state}, {30'b0, ST_IDLE});
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("f_no_done", {31'b0, bus.done}, 32'h0);
    end

`ifdef RESP_TIMEOUT_EN
    // stalled run ends after four idle cycles
    do_start(16'd2, 32'h00000000);
    send_word(32'h00000011);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("g_wait_done", {31'b0, bus.done}, 32'h0);
    end
    tick();
    check("g_done", {31'b0, bus.done}, 32'h1);
    check("g_timeout", {31'b0, bus.timeout}, 32'h1);
    check("g_pass", {31'b0, bus.pass}, 32'h0);
    tick();
    check("g_timeout_hold", {31'b0, bus.timeout}, 32'h1);
`else
    // without the timeout feature a stalled run waits indefinitely
    do_start(16'd2, 32'h00000022);
    send_word(32'h00000011);
    repeat (10) tick();
    check("g_no_done", {31'b0, bus.done}, 32'h0);
    check("g_no_timeout", {31'b0, bus.timeout}, 32'h0);
    check("g_ready", {31'b0, bus.in_ready}, 32'h1);
    send_word(32'h00000000);
    check("g_done", {31'b0, bus.done}, 32'h1);
    check("g_pass", {31'b0, bus.pass}, 32'h1);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/resp_misr_32bit.md
# resp_misr_32bit

Hardware response compactor for MiniMIPS 32-bit datapath units (not/and/or/alu). It consumes a stream of 32-bit result words, folds them into a multiple-input signature register (MISR), and compares the final signature against a golden value. It sits on the output side of a unit under self-test, opposite the stimulus source, and replaces per-word `$monitor` inspection with a single pass/fail.

## Interface
Parameters:
- `POLY`, 32'h04C11DB7, MISR feedback polynomial (bit i set means taps into bit i).
- `SEED`, 32'h00000000, signature value loaded at reset and at every accepted start.
- `TIMEOUT`, 16'd1000, idle cycles tolerated between words (used only with `RESP_TIMEOUT_EN`).

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  begin a run; sampled only in IDLE.
- `length`  input  16  number of words in the run; sampled with `start`.
- `golden`  input  32  expected final signature; sampled with `start`.
- `in_valid`  input  1  `in_data` holds a result word.
- `in_data`  input  32  result word from the unit under test.
- `in_ready`  output  1  high in ACCUM only.
- `busy`  output  1  high in ACCUM and DONE.
- `done`  output  1  one-cycle pulse when a run completes.
- `pass`  output  1  registered at completion: signature equals golden; held until next accepted start.
- `timeout`  output  1  run ended by timeout; held until next accepted start (tied 0 without the macro).
- `signature`  output  32  live MISR register.

## Operation
- States: IDLE, ACCUM, DONE. Reset: state IDLE, `signature`=SEED, count=0, `in_ready`/`busy`/`done`/`pass`/`timeout`=0.
- IDLE: `start`=1 -> latch `length`, `golden`; `signature`<=SEED; count<=0; clear `pass`/`timeout`; go to ACCUM. If `length`=0, go directly to DONE instead (compare uses SEED).
- ACCUM: each cycle with `in_valid`&`in_ready` is one accepted word: `signature` <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ `in_data`; count<=count+1. Arithmetic is pure 32-bit XOR/shift, no carries.
- Accepting word number `length` -> go to DONE; `pass` <= (new signature == golden) in the same edge.
- DONE: `done`=1 for exactly one cycle, then IDLE. `in_ready`=0, so words presented in DONE are not consumed.
- `start` in ACCUM or DONE is ignored; `length`/`golden` changes after start have no effect.
- `in_valid` while not ready: no state change.
- Count is 16 bits; max run 65535 words; no wrap occurs because the run ends at `length`.
- `reset` mid-run: immediate return to reset values; no `done` pulse.

## Timing
- Word accepted on edge N: `signature` reflects it after edge N.
- Last word accepted on edge N: `pass` valid and `done`=1 during cycle N+1; IDLE at N+2; new `start` may be accepted on edge N+2.
- `length`=0: start on edge N -> `done` during cycle N+1.
- Throughput: one word per cycle, no bubbles.

## Configuration
- `RESP_TIMEOUT_EN` defined: an idle counter runs in ACCUM, cleared on each accepted word. Reaching `TIMEOUT` consecutive cycles without an accepted word forces DONE with `pass`=0 and `timeout`=1.
- Not defined: no counter; ACCUM waits indefinitely; `timeout` is constant 0.

## Structure
- Shared package/header: state encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the default POLY constant.
- One sub-module: `misr_step_32bit`, combinational next-signature function (sig, data, POLY -> next). It is reusable by the stimulus-side LFSR.

## Test plan
- Reset, then idle 5 cycles -> `signature`=0, `in_ready`=0, `done`=0, `pass`=0.
- start with length=1, golden=32'h0F0F0F0F; word 32'h0F0F0F0F -> `signature`=0F0F0F0F, `done` pulse one cycle later, `pass`=1.
- length=2, golden=32'h1B3FFDB7; words F000F000 then FFFF0000 -> intermediate F000F000, final 1B3FFDB7, `pass`=1. Repeat with golden=0 -> `pass`=0.
- length=0 -> `done` the cycle after start, `pass`=1 iff golden=SEED. Also assert `start` during ACCUM -> ignored, count unaffected.
- Apply `reset` after the 1st of 3 words -> all outputs return to reset values, no `done`.
- With `RESP_TIMEOUT_EN` and TIMEOUT=4: length=2, send one word, then hold `in_valid`=0 -> DONE after 4 idle cycles, `timeout`=1, `pass`=0.
